// File: rtl/snow64_memory_responder.sv
// Line-granular memory model answering bus-guard accesses, one access at a time.
// Latency: accept edge -> LATENCY busy cycles -> one valid cycle (back-to-back from valid).
// Backpressure: out_busy high while an access is in flight; in_req is ignored then.
module snow64_memory_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_req,
    input  logic [63:0]  in_addr,
    input  logic [255:0] in_data,
    input  logic         in_mem_acc_type,
    output logic         out_valid,
    output logic         out_busy,
    output logic [255:0] out_data
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state, stateNext;
    logic [3:0]            counter, counterNext;
    logic                  accept, perform;
    logic [DEPTH_LOG2-1:0] capIdx;
    logic [255:0]          capData;
    logic                  capWrite;
    logic [255:0]          lines [0:(1<<DEPTH_LOG2)-1];

    // Byte offset and bits above the line index play no part: addresses wrap.
    logic unusedAddr;
    assign unusedAddr = ^{in_addr[63:5+DEPTH_LOG2], in_addr[4:0]};

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        accept      = 1'b0;
        perform     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (in_req) begin
                    accept      = 1'b1;
                    counterNext = 4'(LATENCY - 1);
                    stateNext   = WAIT;
                end else begin
                    stateNext = IDLE;
                end
            end
            WAIT: begin
                if (counter != 4'd0) begin
                    counterNext = counter - 4'd1;
                end else begin
                    perform   = 1'b1;
                    stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capIdx   <= '0;
            capData  <= '0;
            capWrite <= 1'b0;
        end else if (accept) begin
            capIdx   <= in_addr[5 +: DEPTH_LOG2];
            capData  <= in_data;
            capWrite <= in_mem_acc_type;
        end
    end

    // Storage survives reset; perform is low whenever reset holds state in IDLE.
    always_ff @(posedge clk) begin
        if (perform && capWrite) begin
            lines[capIdx] <= capData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (perform && !capWrite) begin
            out_data <= lines[capIdx];
        end
    end

    assign out_busy  = (state == WAIT);
    assign out_valid = (state == DONE);

endmodule
